muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the five-stage MIPS pipeline. It replaces the single-cycle HI/LO commit path, and sits beside the ALU in EX. It accepts mult/multu/div/divu (plus optional accumulate ops) through a start strobe. It asserts `busy` for a parametrised latency so hazard control can stall mfhi/mflo and further multiply/divide instructions. HI/LO can also be written directly by mthi/mtlo.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MULT_CYCLES`, 5: busy cycles for multiply-class ops, legal range 1..255.
- `DIV_CYCLES`, 10: busy cycles for divide-class ops, legal range 1..255.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch the operation in `op` with operands `a`, `b`.
- `op`  in  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu.
- `a`  in  WIDTH  rs operand (dividend / multiplicand).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `load_HI`  in  1  mthi: write `load_value` to HI.
- `load_LO`  in  1  mtlo: write `load_value` to LO.
- `load_value`  in  WIDTH  data for mthi/mtlo.
- `busy`  out  1  an operation is in flight.
- `HI`  out  WIDTH  architectural HI.
- `LO`  out  WIDTH  architectural LO.

## Operation
- States: IDLE and RUN. There is a down-counter `cnt` of 8 bits.
- IDLE with `start=1`:
  - The result is computed from `a`, `b`, `op` and latched into pending registers `pHI` and `pLO`.
  - `cnt` is loaded with `MULT_CYCLES` or `DIV_CYCLES`, and the state moves to RUN.
- RUN:
  - `cnt` decrements every cycle.
  - On the cycle `cnt==1`, `pHI` and `pLO` are written to HI and LO, and the state returns to IDLE.
- `start` asserted while in RUN is ignored and has no effect. Hazard control must never do this; the bench flags it as a warning.
- Multiply results:
  - mult: signed 2·WIDTH product.
  - multu: unsigned 2·WIDTH product.
  - Upper half goes to HI, lower half to LO.
- Divide results:
  - div is signed, quotient truncated toward zero, into LO. The remainder takes the sign of the dividend and goes to HI.
  - divu is unsigned.
  - Divisor 0: the op runs its full latency, and HI/LO are left unchanged at completion.
  - Signed most-negative ÷ −1 gives LO = most-negative and HI = 0.
- mthi/mtlo:
  - `load_HI`/`load_LO` write on the next edge when in IDLE.
  - In RUN they are ignored, because hazard control stalls them.
  - A load in the same cycle as an accepted `start` is applied. Accumulate ops then see the loaded value.
- `busy` = (state == RUN).
- HI and LO hold their old values throughout RUN.

## Timing
- Reset: state IDLE, `cnt`=0, `busy`=0, HI=0, LO=0, and pending registers 0.
- `start` sampled at edge t:
  - `busy` is 1 for cycles t+1 … t+N, where N is the op latency.
  - New HI/LO values are visible, with `busy`=0, from cycle t+N+1.
- A back-to-back `start` is accepted in the first cycle `busy`=0.
- Reset asserted mid-operation:
  - The operation is abandoned and the pending result is discarded.
  - All outputs take their reset values on the next edge.
- `reset` has priority over `start` and the loads.

## Configuration
- `MULDIV_MADD_EN` defined:
  - op 4 (madd) adds the signed product to {HI,LO}; op 5 (maddu) adds the unsigned product.
  - ops 6 and 7 (msub, msubu) subtract the product from {HI,LO}.
  - The accumulator is the value of {HI,LO} at completion, modulo 2^(2·WIDTH). Latency is `MULT_CYCLES`.
- `MULDIV_MADD_EN` undefined:
  - ops 4–7 are treated as a no-op start. `busy` stays 0, and HI/LO are unchanged.
  - The accumulate adder is not synthesised.

## Test plan
- Reset, then mult with a=0xFFFFFFFE (−2), b=3 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div with a=−7, b=2 → `busy` 10 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Then divu with b=0 → HI/LO unchanged.
- mthi 0x12345678 in IDLE → HI=0x12345678 next cycle.
- Issue div, then assert `load_LO` and `start` during RUN → both ignored; only the div result appears.
- Start mult, assert `reset` at busy cycle 3 → `busy`=0 and HI=LO=0 next cycle.
- With `MULDIV_MADD_EN`: HI=0, LO=0xFFFFFFFF, maddu with a=1, b=1 → HI=1, LO=0.
- Without `MULDIV_MADD_EN`: the same maddu → `busy` stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS multiply/divide unit with architectural HI/LO and mthi/mtlo loads.
// Latency: busy for MULT_CYCLES (mult class) or DIV_CYCLES (div class) cycles after start; HI/LO update as busy drops.
// Backpressure: none internally; start and loads are ignored while busy, so hazard control must stall them.
// Optional feature macro: MULDIV_MADD_EN enables madd/maddu/msub/msubu (ops 4-7); otherwise those ops are no-ops.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load_HI,
    input  logic             load_LO,
    input  logic [WIDTH-1:0] load_value,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [7:0]         cnt, cnt_next;
    logic               launch, finish;

    // Pending result captured at launch, committed at completion
    logic [WIDTH-1:0]   p_hi, p_lo;
    logic               p_write;

    // Decoded result of the operation presented on op/a/b
    logic               op_ok, op_write;
    logic [7:0]         op_cycles;
    logic [WIDTH-1:0]   op_hi, op_lo;

    // Multiplier: both products formed at 2*WIDTH so the low half is exact
    logic [2*WIDTH-1:0] sprod, uprod, prod;

    // Divider: magnitude divide, then signs restored (avoids the min/-1 overflow)
    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, div_den, uquo, urem, quo, rem;

`ifdef MULDIV_MADD_EN
    logic               op_acc, op_sub, p_acc, p_sub;
    logic [2*WIDTH-1:0] acc_sum;
`endif

    assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod  = op[0] ? uprod : sprod;

    assign sgn     = ~op[0];
    assign a_neg   = sgn & a[WIDTH-1];
    assign b_neg   = sgn & b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign div_den = (b_mag == '0) ? WIDTH'(1) : b_mag;
    assign uquo    = a_mag / div_den;
    assign urem    = a_mag % div_den;
    assign quo     = (a_neg ^ b_neg) ? -uquo : uquo;
    assign rem     = a_neg ? -urem : urem;

`ifdef MULDIV_MADD_EN
    assign acc_sum = p_sub ? ({HI, LO} - {p_hi, p_lo}) : ({HI, LO} + {p_hi, p_lo});
`endif

    assign busy = (state == RUN);

    // Decode op into result, latency and whether HI/LO get written at completion
    always_comb begin
        op_ok     = 1'b0;
        op_write  = 1'b0;
        op_cycles = 8'd0;
        op_hi     = '0;
        op_lo     = '0;
`ifdef MULDIV_MADD_EN
        op_acc    = 1'b0;
        op_sub    = 1'b0;
`endif
        case (op)
            3'd0, 3'd1: begin
                op_ok          = 1'b1;
                op_write       = 1'b1;
                op_cycles      = 8'(MULT_CYCLES);
                {op_hi, op_lo} = prod;
            end
            3'd2, 3'd3: begin
                op_ok     = 1'b1;
                op_write  = (b != '0);
                op_cycles = 8'(DIV_CYCLES);
                op_hi     = rem;
                op_lo     = quo;
            end
            default: begin
`ifdef MULDIV_MADD_EN
                op_ok          = 1'b1;
                op_write       = 1'b1;
                op_cycles      = 8'(MULT_CYCLES);
                {op_hi, op_lo} = prod;
                op_acc         = 1'b1;
                op_sub         = op[1];
`endif
            end
        endcase
    end

    // Next-state logic: launch from IDLE, count down in RUN, finish when cnt reaches 1
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && op_ok) begin
                    launch     = 1'b1;
                    cnt_next   = op_cycles;
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // HI/LO and pending result; loads only land in IDLE, commits only on the finish cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            p_write <= 1'b0;
`ifdef MULDIV_MADD_EN
            p_acc   <= 1'b0;
            p_sub   <= 1'b0;
`endif
        end else begin
            if (state == IDLE) begin
                if (load_HI) HI <= load_value;
                if (load_LO) LO <= load_value;
            end
            if (launch) begin
                p_hi    <= op_hi;
                p_lo    <= op_lo;
                p_write <= op_write;
`ifdef MULDIV_MADD_EN
                p_acc   <= op_acc;
                p_sub   <= op_sub;
`endif
            end
            if (finish && p_write) begin
`ifdef MULDIV_MADD_EN
                if (p_acc) begin
                    HI <= acc_sum[2*WIDTH-1:WIDTH];
                    LO <= acc_sum[WIDTH-1:0];
                end else begin
                    HI <= p_hi;
                    LO <= p_lo;
                end
`else
                HI <= p_hi;
                LO <= p_lo;
`endif
            end
        end
    end

endmodule
